// File: rtl/div_hilo_writeback.sv
// Post-divider writeback: captures the unsigned divider result, applies signed-division
// correction and writes the quotient to LO, then the remainder to HI, over the shared bus.
module div_hilo_writeback #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [2*WIDTH-1:0] z_in,
    input  logic               signed_op,
    input  logic               dividend_sign,
    input  logic               divisor_sign,
    input  logic               divisor_zero,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   bus_out,
    output logic               lo_in,
    output logic               hi_in,
    output logic               div_zero_flag
);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StFix,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e             state_q;
    logic [2*WIDTH-1:0] z_q;
    logic               signed_q;
    logic               dvd_sign_q;
    logic               dvs_sign_q;
    logic               dvs_zero_q;
    logic [WIDTH-1:0]   r_q;

    logic [WIDTH-1:0]   quot_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Divider delivers magnitudes; negation is mod 2^WIDTH so 0x8000_0000 maps to itself.
    always_comb begin
        quot_mag = z_q[2*WIDTH-1:WIDTH];
        rem_mag  = z_q[WIDTH-1:0];
        q_fix    = quot_mag;
        r_fix    = rem_mag;
        if (dvs_zero_q) begin
            q_fix = ZERO_Q;
        end else if (signed_q && (dvd_sign_q ^ dvs_sign_q)) begin
            q_fix = ~quot_mag + 1'b1;
        end
        // Applies on divide-by-zero too, so HI recovers the original dividend.
        if (signed_q && dvd_sign_q) begin
            r_fix = ~rem_mag + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q       <= StIdle;
            z_q           <= '0;
            signed_q      <= 1'b0;
            dvd_sign_q    <= 1'b0;
            dvs_sign_q    <= 1'b0;
            dvs_zero_q    <= 1'b0;
            r_q           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus_out       <= '0;
            lo_in         <= 1'b0;
            hi_in         <= 1'b0;
            div_zero_flag <= 1'b0;
        end else begin
            done    <= 1'b0;
            lo_in   <= 1'b0;
            hi_in   <= 1'b0;
            bus_out <= '0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StCapture;
                        busy          <= 1'b1;
                        z_q           <= z_in;
                        signed_q      <= signed_op;
                        dvd_sign_q    <= dividend_sign;
                        dvs_sign_q    <= divisor_sign;
                        dvs_zero_q    <= divisor_zero;
                        div_zero_flag <= divisor_zero;
                    end
                end
                StCapture: begin
                    state_q <= StFix;
                end
                StFix: begin
                    state_q <= StWrLo;
                    r_q     <= r_fix;
                    bus_out <= q_fix;
                    lo_in   <= 1'b1;
                end
                StWrLo: begin
                    state_q <= StWrHi;
                    bus_out <= r_q;
                    hi_in   <= 1'b1;
                end
                StWrHi: begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_writeback.sv
// Directed, table-driven bench for div_hilo_writeback with hand-written corner sequences.
module tb_div_hilo_writeback;

    localparam int unsigned WIDTH = 32;

    logic               clock;
    logic               clear;
    logic               start;
    logic [2*WIDTH-1:0] z_in;
    logic               signed_op;
    logic               dividend_sign;
    logic               divisor_sign;
    logic               divisor_zero;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   bus_out;
    logic               lo_in;
    logic               hi_in;
    logic               div_zero_flag;

    div_hilo_writeback #(
        .WIDTH (WIDTH),
        .ZERO_Q(32'hFFFF_FFFF)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .z_in         (z_in),
        .signed_op    (signed_op),
        .dividend_sign(dividend_sign),
        .divisor_sign (divisor_sign),
        .divisor_zero (divisor_zero),
        .busy         (busy),
        .done         (done),
        .bus_out      (bus_out),
        .lo_in        (lo_in),
        .hi_in        (hi_in),
        .div_zero_flag(div_zero_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] z;
        logic        sop;
        logic        ds;
        logic        vs;
        logic        dz;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t vecs[9];

    int tests;
    int fails;
    int lo_cnt;
    int hi_cnt;
    logic prev_flag;

    always @(negedge clock) begin
        if (lo_in) lo_cnt++;
        if (hi_in) hi_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full operation; with hold=1 start stays high and z_in churns every cycle.
    task automatic do_op(input string tag, input vec_t v, input bit hold);
        @(negedge clock);
        check({tag, " flag_before_start"}, 64'(div_zero_flag), 64'(prev_flag));
        z_in          = v.z;
        signed_op     = v.sop;
        dividend_sign = v.ds;
        divisor_sign  = v.vs;
        divisor_zero  = v.dz;
        start         = 1'b1;
        @(posedge clock); #1;
        check({tag, " busy_capture"}, 64'(busy), 64'd1);
        check({tag, " flag_at_start"}, 64'(div_zero_flag), 64'(v.dz));
        if (!hold) start = 1'b0;
        z_in          = {$urandom(), $urandom()};
        signed_op     = ~v.sop;
        dividend_sign = ~v.ds;
        divisor_sign  = ~v.vs;
        divisor_zero  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            if (hold) z_in = {$urandom(), $urandom()};
            case (c)
                1: check({tag, " fix_no_lo"}, 64'({busy, lo_in, hi_in}), 64'b100);
                2: begin
                    check({tag, " lo_strobe"}, 64'({lo_in, hi_in}), 64'b10);
                    check({tag, " lo_value"}, 64'(bus_out), 64'(v.exp_lo));
                end
                3: begin
                    check({tag, " hi_strobe"}, 64'({lo_in, hi_in}), 64'b01);
                    check({tag, " hi_value"}, 64'(bus_out), 64'(v.exp_hi));
                end
                default: check({tag, " done_pulse"}, 64'({done, busy, bus_out}), 64'h2_0000_0000);
            endcase
        end
        prev_flag = v.dz;
        @(posedge clock); #1;
        check({tag, " idle_after_done"}, 64'({done, busy}), 64'b00);
    endtask

    initial begin
        int lo0;
        int hi0;
        tests = 0;
        fails = 0;
        lo_cnt = 0;
        hi_cnt = 0;
        prev_flag = 1'b0;

        //               z                               sop   ds    vs    dz    lo              hi
        vecs[0] = '{{32'd14, 32'd2},                    1'b0, 1'b0, 1'b0, 1'b0, 32'd14,         32'd2};
        vecs[1] = '{{32'd14, 32'd2},                    1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
        vecs[2] = '{{32'd14, 32'd2},                    1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF2, 32'd2};
        vecs[3] = '{{32'd14, 32'd2},                    1'b1, 1'b1, 1'b1, 1'b0, 32'd14,         32'hFFFF_FFFE};
        vecs[4] = '{{32'd14, 32'd2},                    1'b0, 1'b1, 1'b0, 1'b0, 32'd14,         32'd2};
        vecs[5] = '{{32'hFFFF_FFFF, 32'd5},             1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[6] = '{{32'd3, 32'd0},                     1'b0, 1'b0, 1'b0, 1'b0, 32'd3,          32'd0};
        vecs[7] = '{{32'h8000_0000, 32'd0},             1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0};
        vecs[8] = '{{32'hFFFF_FFFF, 32'd7},             1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd7};

        clear = 1'b0;
        start = 1'b0;
        z_in = '0;
        signed_op = 1'b0;
        dividend_sign = 1'b0;
        divisor_sign = 1'b0;
        divisor_zero = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", 64'({busy, done, lo_in, hi_in, div_zero_flag, bus_out}), 64'd0);
        @(negedge clock);
        clear = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Start held high with churning inputs: one write pair, restart only from IDLE.
        lo0 = lo_cnt;
        hi0 = hi_cnt;
        do_op("hold", vecs[1], 1'b1);
        check("hold_lo_count", 64'(lo_cnt - lo0), 64'd1);
        check("hold_hi_count", 64'(hi_cnt - hi0), 64'd1);
        @(posedge clock); #1;
        check("hold_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        divisor_zero = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("hold_second_idle", 64'({busy, done}), 64'b00);
        prev_flag = 1'b0;

        // Asynchronous clear during WR_LO.
        do_op("flag_set", vecs[5], 1'b0);
        @(negedge clock);
        z_in = vecs[0].z;
        signed_op = 1'b0;
        dividend_sign = 1'b0;
        divisor_sign = 1'b0;
        divisor_zero = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("abort_in_wr_lo", 64'({lo_in, bus_out}), 64'h1_0000_000E);
        hi0 = hi_cnt;
        #1 clear = 1'b0;
        #1;
        check("abort_outputs", 64'({busy, done, lo_in, hi_in, div_zero_flag, bus_out}), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("abort_no_hi", 64'(hi_cnt - hi0), 64'd0);
        check("abort_held_idle", 64'({busy, done}), 64'b00);
        @(negedge clock);
        clear = 1'b1;
        prev_flag = 1'b0;
        do_op("after_abort", vecs[2], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
